uart_frame_assembler: RTL and testbench
=======================================

// Module: uart_frame_assembler
// PURPOSE
//  Sits between the UART receive path and the coprocessor.
//  Collects FRAME_BYTES received bytes into one wide word and presents it on a valid/ready output.
//  An inter-byte timeout discards partial frames.
//  Replaces the ad-hoc char counter in the top level; its output drives the coprocessor din/din_valid.
// PARAMETERS
//  DBITS           8        bits per UART character
//  FRAME_BYTES     4        bytes per frame (>=1)
//  TIMEOUT_CYCLES  1000000  clk cycles of byte inactivity that abort a partial frame; 0 = timeout disabled
// PORTS
//  clk          in   1                  system clock
//  reset        in   1                  synchronous, active-high
//  byte_in      in   DBITS              received character
//  byte_valid   in   1                  1-cycle pulse, byte_in valid
//  frame_out    out  FRAME_BYTES*DBITS  assembled frame; first byte in [DBITS-1:0]
//  frame_valid  out  1                  frame available; held until accepted
//  frame_ready  in   1                  consumer accepts frame (tie 1 for pulse-style sinks)
//  byte_count   out  $clog2(FRAME_BYTES+1)  bytes held in the current partial frame
//  busy         out  1                  high in COLLECT or HOLD
//  timeout_err  out  1                  1-cycle pulse: partial frame discarded
//  overrun_err  out  1                  1-cycle pulse: byte dropped while frame pending
// BEHAVIOUR
//  Reset values: frame_out=0, frame_valid=0, byte_count=0, busy=0, timeout_err=0, overrun_err=0, state=IDLE, timer=0.
//  Reset has priority over every other event, including mid-frame and during HOLD. Partial data is lost.
//  States:
//   IDLE:
//    - byte_valid: byte goes to slot 0, count=1, timer=0.
//    - Next state is HOLD if FRAME_BYTES==1, else COLLECT.
//   COLLECT:
//    - byte_valid: byte goes to slot[count], count++, timer=0.
//    - When the stored byte is the last one, next state is HOLD.
//    - No byte_valid: timer++.
//    - timer==TIMEOUT_CYCLES-1 with no byte_valid: pulse timeout_err, count=0, go to IDLE.
//    - byte_valid on that same cycle wins: it is stored and there is no timeout.
//   HOLD:
//    - frame_valid=1. frame_out is stable and count==FRAME_BYTES.
//    - frame_valid&&frame_ready: handshake; next state is IDLE, count=0.
//    - Handshake and byte_valid in the same cycle: the byte becomes slot 0 of the next frame.
//      count=1, next state is COLLECT (or HOLD if FRAME_BYTES==1).
//    - byte_valid without handshake: byte dropped, pulse overrun_err, frame_out unchanged.
//    - No timeout runs in HOLD.
//  Latency: frame_valid rises the cycle after the final byte_valid.
//  Unused slots are not cleared between frames. Only the count is meaningful.
//  frame_out changes only on byte stores, never while frame_valid=1.
//  Timer width is $clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.
//  Error pulses are registered and last exactly one cycle.
// STRUCTURE
//  Shared package uart_pkg:
//   - DBITS default
//   - state localparams ST_IDLE/ST_COLLECT/ST_HOLD (2-bit)
//   - default TIMEOUT_CYCLES derived from CLK_FREQ/baud (~10 char times)
//  One sub-module, uart_idle_timer:
//   - params N; ports clk, reset, clear, enable, expired
//   - counts enabled cycles, clear has priority, expired is a 1-cycle pulse at N-1
//   - N==0 ties expired to 0
//  Slot write uses count as an index into frame_out. No separate shift register.
// TESTING
//  1. FRAME_BYTES=4, ready=1; bytes 11,22,33,44 ->
//     frame_out=32'h44332211, frame_valid for 1 cycle, 1 cycle after byte 44.
//  2. ready=0 after a full frame; send byte 55 ->
//     overrun_err pulse, frame_out stays 44332211;
//     raise ready -> handshake, byte_count=0.
//  3. TIMEOUT_CYCLES=16; bytes AA,BB then idle 16 cycles ->
//     timeout_err on cycle 16, byte_count=0;
//     next 4 bytes form a clean frame.
//  4. Byte at exactly timer=15 (TIMEOUT_CYCLES=16) -> no timeout_err, byte stored.
//  5. Handshake coincident with byte 99 -> byte_count=1 and slot 0=99 after the cycle, no error.
//  6. reset asserted with 3 bytes held or in HOLD ->
//     all outputs 0 next cycle; subsequent frame assembles normally.
//  Also: FRAME_BYTES=1 (every byte becomes a frame); TIMEOUT_CYCLES=0 (never times out).

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: character width default, frame-assembler state
// encoding, and a default inter-byte timeout of roughly ten character times.
package uart_pkg;

  localparam int unsigned DBITS_DEF     = 8;

  // 96 MHz / 9600 baud = 10000 clk per bit. One character is 10 bits
  // (start + 8 data + stop). Ten characters give 1_000_000 cycles.
  localparam int unsigned CLK_FREQ      = 96_000_000;
  localparam int unsigned BAUD          = 9600;
  localparam int unsigned CHAR_BITS     = 10;
  localparam int unsigned TIMEOUT_CHARS = 10;
  localparam int unsigned TIMEOUT_DEF   = (CLK_FREQ / BAUD) * CHAR_BITS * TIMEOUT_CHARS;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } state_e;

endpackage

// File: rtl/uart_idle_timer.sv
// Idle-cycle counter used to abort partial frames.
//  clk, reset : clock, synchronous active-high reset
//  clear      : zero the count (wins over enable)
//  enable     : count this cycle
//  expired    : 1-cycle pulse on the enabled, uncleared cycle where count==N-1
// N==0 disables the timer (expired tied low).
module uart_idle_timer #(
  parameter int unsigned N = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (N == 0) begin : g_off
      logic unused_in;
      assign unused_in = ^{clk, reset, clear, enable};
      assign expired   = 1'b0;
    end else begin : g_on
      localparam int TW = $clog2(N + 1);
      logic [TW-1:0] cnt_q, cnt_d;

      // Saturates at N so a long idle never wraps back into range.
      always_comb begin
        cnt_d = cnt_q;
        if (clear)
          cnt_d = '0;
        else if (enable && (cnt_q != TW'(N)))
          cnt_d = cnt_q + TW'(1);
      end

      always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
      end

      assign expired = enable && !clear && (cnt_q == TW'(N - 1));
    end
  endgenerate

endmodule

// File: rtl/uart_frame_assembler.sv
// Collects FRAME_BYTES UART characters into one word and offers it on a
// valid/ready interface; a partial frame is discarded after TIMEOUT_CYCLES
// idle cycles (0 disables the timeout).
//  clk, reset   : clock, synchronous active-high reset
//  byte_in      : received character, qualified by byte_valid (1-cycle pulse)
//  frame_out    : assembled frame, first byte in [DBITS-1:0]
//  frame_valid  : frame available, held until frame_ready
//  frame_ready  : consumer accepts frame
//  byte_count   : bytes held in the current frame
//  busy         : collecting or holding a frame
//  timeout_err  : 1-cycle pulse, partial frame discarded
//  overrun_err  : 1-cycle pulse, byte dropped while a frame is pending
module uart_frame_assembler
  import uart_pkg::*;
#(
  parameter int unsigned DBITS          = DBITS_DEF,
  parameter int unsigned FRAME_BYTES    = 4,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [DBITS-1:0]                     byte_in,
  input  logic                                 byte_valid,
  output logic [FRAME_BYTES*DBITS-1:0]         frame_out,
  output logic                                 frame_valid,
  input  logic                                 frame_ready,
  output logic [$clog2(FRAME_BYTES+1)-1:0]     byte_count,
  output logic                                 busy,
  output logic                                 timeout_err,
  output logic                                 overrun_err
);

  localparam int CW = $clog2(FRAME_BYTES + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME_BYTES - 1);
  localparam state_e FIRST_NEXT = (FRAME_BYTES == 1) ? ST_HOLD : ST_COLLECT;

  state_e                              state_q, state_d;
  logic [CW-1:0]                       count_q, count_d;
  logic [FRAME_BYTES-1:0][DBITS-1:0]   slots_q, slots_d;
  logic                                tmo_q, tmo_d;
  logic                                ovr_q, ovr_d;
  logic                                store;
  logic [CW-1:0]                       wr_slot;
  logic                                expired;

  // Timer only runs while collecting; any byte or other state restarts it.
  uart_idle_timer #(.N(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (byte_valid || (state_q != ST_COLLECT)),
    .enable  (state_q == ST_COLLECT),
    .expired (expired)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    store   = 1'b0;
    wr_slot = count_q;
    tmo_d   = 1'b0;
    ovr_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (byte_valid) begin
          store   = 1'b1;
          wr_slot = '0;
          count_d = CW'(1);
          state_d = FIRST_NEXT;
        end
      end
      ST_COLLECT: begin
        // A byte on the expiry cycle wins over the timeout.
        if (byte_valid) begin
          store   = 1'b1;
          count_d = count_q + CW'(1);
          if (count_q == LAST) state_d = ST_HOLD;
        end else if (expired) begin
          tmo_d   = 1'b1;
          count_d = '0;
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (frame_ready) begin
          if (byte_valid) begin
            // Byte accepted alongside the handshake starts the next frame.
            store   = 1'b1;
            wr_slot = '0;
            count_d = CW'(1);
            state_d = FIRST_NEXT;
          end else begin
            count_d = '0;
            state_d = ST_IDLE;
          end
        end else if (byte_valid) begin
          ovr_d = 1'b1;
        end
      end
      default: begin
        count_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Only the addressed slot is written; stale slots are left as they are.
  always_comb begin
    slots_d = slots_q;
    for (int i = 0; i < FRAME_BYTES; i++)
      if (store && (wr_slot == CW'(i))) slots_d[i] = byte_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      slots_q <= '0;
      tmo_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      slots_q <= slots_d;
      tmo_q   <= tmo_d;
      ovr_q   <= ovr_d;
    end
  end

  assign frame_out   = slots_q;
  assign frame_valid = (state_q == ST_HOLD);
  assign byte_count  = count_q;
  assign busy        = (state_q != ST_IDLE);
  assign timeout_err = tmo_q;
  assign overrun_err = ovr_q;

endmodule

// File: tb/tb_uart_frame_assembler.sv
module tb_uart_frame_assembler;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // A: FRAME_BYTES=4, TIMEOUT=16
  logic [7:0]  a_in;   logic a_v, a_rdy, a_fv, a_busy, a_tmo, a_ovr;
  logic [31:0] a_out;  logic [2:0] a_cnt;
  // B: FRAME_BYTES=1, TIMEOUT=16
  logic [7:0]  b_in;   logic b_v, b_rdy, b_fv, b_busy, b_tmo, b_ovr;
  logic [7:0]  b_out;  logic [0:0] b_cnt;
  // C: FRAME_BYTES=4, TIMEOUT disabled
  logic [7:0]  c_in;   logic c_v, c_rdy, c_fv, c_busy, c_tmo, c_ovr;
  logic [31:0] c_out;  logic [2:0] c_cnt;

  uart_frame_assembler #(.DBITS(8), .FRAME_BYTES(4), .TIMEOUT_CYCLES(16)) dut_a (
    .clk(clk), .reset(reset), .byte_in(a_in), .byte_valid(a_v), .frame_out(a_out),
    .frame_valid(a_fv), .frame_ready(a_rdy), .byte_count(a_cnt), .busy(a_busy),
    .timeout_err(a_tmo), .overrun_err(a_ovr));

  uart_frame_assembler #(.DBITS(8), .FRAME_BYTES(1), .TIMEOUT_CYCLES(16)) dut_b (
    .clk(clk), .reset(reset), .byte_in(b_in), .byte_valid(b_v), .frame_out(b_out),
    .frame_valid(b_fv), .frame_ready(b_rdy), .byte_count(b_cnt), .busy(b_busy),
    .timeout_err(b_tmo), .overrun_err(b_ovr));

  uart_frame_assembler #(.DBITS(8), .FRAME_BYTES(4), .TIMEOUT_CYCLES(0)) dut_c (
    .clk(clk), .reset(reset), .byte_in(c_in), .byte_valid(c_v), .frame_out(c_out),
    .frame_valid(c_fv), .frame_ready(c_rdy), .byte_count(c_cnt), .busy(c_busy),
    .timeout_err(c_tmo), .overrun_err(c_ovr));

  int n_tests = 0;
  int n_fail  = 0;
  int n_pops  = 0;
  int n_push  = 0;
  logic [31:0] exp_q[$];

  // Scoreboard: every handshake on A must deliver the next expected frame.
  always @(negedge clk) begin
    if (!reset && a_fv && a_rdy) begin
      n_tests++;
      n_pops++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_frame got=%h expected=none", a_out);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (a_out !== e) begin
          n_fail++;
          $display("FAIL sb_frame got=%h expected=%h", a_out, e);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_a(input logic [7:0] b);
    a_in = b; a_v = 1'b1;
    tick();
    a_v = 1'b0;
  endtask

  task automatic push(input logic [31:0] f);
    exp_q.push_back(f);
    n_push++;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    // Local compare kept per call site; prints the failing name and values.
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(2);
    chk("rst_frame_out", a_out, 32'h0);
    chk("rst_outputs", {28'h0, a_fv, a_busy, a_tmo, a_ovr}, 32'h0);
    chk("rst_count", {29'h0, a_cnt}, 32'h0);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_frame();
    a_rdy = 1'b1;
    send_a(8'h11); send_a(8'h22); send_a(8'h33);
    chk("basic_count3", {29'h0, a_cnt}, 32'd3);
    push(32'h44332211);
    send_a(8'h44);
    chk("basic_valid_after_last", {31'h0, a_fv}, 32'd1);
    chk("basic_frame_out", a_out, 32'h44332211);
    tick();
    chk("basic_valid_one_cycle", {31'h0, a_fv}, 32'd0);
    chk("basic_count_cleared", {29'h0, a_cnt}, 32'd0);
  endtask

  task automatic test_overrun();
    a_rdy = 1'b0;
    send_a(8'h01); send_a(8'h02); send_a(8'h03);
    push(32'h04030201);
    send_a(8'h04);
    send_a(8'h55);
    chk("ovr_pulse", {31'h0, a_ovr}, 32'd1);
    chk("ovr_frame_kept", a_out, 32'h04030201);
    chk("ovr_count", {29'h0, a_cnt}, 32'd4);
    tick();
    chk("ovr_pulse_one_cycle", {31'h0, a_ovr}, 32'd0);
    chk("ovr_still_valid", {31'h0, a_fv}, 32'd1);
    a_rdy = 1'b1;
    tick();
    chk("ovr_handshake_count", {29'h0, a_cnt}, 32'd0);
    chk("ovr_handshake_valid", {31'h0, a_fv}, 32'd0);
  endtask

  task automatic test_timeout();
    logic early;
    early = 1'b0;
    send_a(8'hAA); send_a(8'hBB);
    for (int i = 0; i < 15; i++) begin
      tick();
      if (a_tmo !== 1'b0 || a_cnt !== 3'd2) early = 1'b1;
    end
    chk("tmo_not_early", {31'h0, early}, 32'd0);
    tick();
    chk("tmo_pulse", {31'h0, a_tmo}, 32'd1);
    chk("tmo_count", {29'h0, a_cnt}, 32'd0);
    chk("tmo_busy", {31'h0, a_busy}, 32'd0);
    tick();
    chk("tmo_pulse_one_cycle", {31'h0, a_tmo}, 32'd0);
    send_a(8'hD1); send_a(8'hD2); send_a(8'hD3);
    push(32'hD4D3D2D1);
    send_a(8'hD4);
    chk("tmo_clean_frame", a_out, 32'hD4D3D2D1);
    tick();
  endtask

  task automatic test_timeout_edge();
    send_a(8'hC1);
    tick(15);
    send_a(8'hC2);
    chk("edge_no_tmo", {31'h0, a_tmo}, 32'd0);
    chk("edge_stored", {29'h0, a_cnt}, 32'd2);
    send_a(8'hC3);
    push(32'hC4C3C2C1);
    send_a(8'hC4);
    chk("edge_frame", a_out, 32'hC4C3C2C1);
    tick();
  endtask

  task automatic test_back_to_back();
    a_rdy = 1'b0;
    send_a(8'h61); send_a(8'h62); send_a(8'h63);
    push(32'h64636261);
    send_a(8'h64);
    a_rdy = 1'b1;
    send_a(8'h99);
    chk("b2b_count", {29'h0, a_cnt}, 32'd1);
    chk("b2b_slot0", {24'h0, a_out[7:0]}, 32'h99);
    chk("b2b_errs", {30'h0, a_tmo, a_ovr}, 32'd0);
    chk("b2b_collect", {30'h0, a_busy, a_fv}, 32'd2);
    send_a(8'hA2); send_a(8'hA3);
    push(32'hA4A3A299);
    send_a(8'hA4);
    tick();
  endtask

  task automatic test_reset_mid();
    send_a(8'h71); send_a(8'h72); send_a(8'h73);
    reset = 1'b1;
    tick();
    chk("rmid_outputs", {25'h0, a_cnt, a_fv, a_busy, a_tmo, a_ovr}, 32'h0);
    chk("rmid_frame_out", a_out, 32'h0);
    reset = 1'b0;
    a_rdy = 1'b0;
    send_a(8'h81); send_a(8'h82); send_a(8'h83); send_a(8'h84);
    chk("rhold_valid", {31'h0, a_fv}, 32'd1);
    reset = 1'b1;
    tick();
    chk("rhold_outputs", {25'h0, a_cnt, a_fv, a_busy, a_tmo, a_ovr}, 32'h0);
    reset = 1'b0;
    a_rdy = 1'b1;
    send_a(8'h91); send_a(8'h92); send_a(8'h93);
    push(32'h94939291);
    send_a(8'h94);
    chk("rafter_frame", a_out, 32'h94939291);
    tick();
  endtask

  task automatic test_single_byte_frames();
    logic [7:0] pat[3];
    pat[0] = 8'h5A; pat[1] = 8'hA5; pat[2] = 8'h3C;
    b_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b_in = pat[i]; b_v = 1'b1;
      tick();
      b_v = 1'b0;
      chk("fb1_valid", {31'h0, b_fv}, 32'd1);
      chk("fb1_data", {24'h0, b_out}, {24'h0, pat[i]});
      tick();
      chk("fb1_released", {31'h0, b_fv}, 32'd0);
    end
    b_rdy = 1'b0;
    b_in = 8'hE1; b_v = 1'b1; tick();
    b_in = 8'hE2; tick();
    b_v = 1'b0;
    chk("fb1_overrun", {31'h0, b_ovr}, 32'd1);
    chk("fb1_kept", {24'h0, b_out}, 32'hE1);
    b_rdy = 1'b1; tick();
  endtask

  task automatic test_no_timeout();
    logic bad;
    bad = 1'b0;
    c_rdy = 1'b1;
    c_in = 8'h10; c_v = 1'b1; tick();
    c_in = 8'h20; tick();
    c_v = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (c_tmo !== 1'b0 || c_cnt !== 3'd2) bad = 1'b1;
    end
    chk("t0_never_times_out", {31'h0, bad}, 32'd0);
    c_in = 8'h30; c_v = 1'b1; tick();
    c_in = 8'h40; tick();
    c_v = 1'b0;
    chk("t0_valid", {31'h0, c_fv}, 32'd1);
    chk("t0_frame", c_out, 32'h40302010);
    tick();
  endtask

  initial begin
    reset = 1'b1;
    a_in = '0; a_v = 1'b0; a_rdy = 1'b1;
    b_in = '0; b_v = 1'b0; b_rdy = 1'b1;
    c_in = '0; c_v = 1'b0; c_rdy = 1'b1;
    test_reset();
    test_basic_frame();
    test_overrun();
    test_timeout();
    test_timeout_edge();
    test_back_to_back();
    test_reset_mid();
    test_single_byte_frames();
    test_no_timeout();
    tick(2);
    chk("sb_all_frames_seen", n_pops, n_push);
    chk("sb_queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
